// File: rtl/aq_mux_pkg.sv
// aq_scan_mux shared types and helpers.
// Mode/state enums, default error pattern, clog2.
package aq_mux_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN,
        HOLD
    } state_e;

    localparam logic [7:0] ERR_PATTERN_DEF = 8'h40;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/aq_onehot_check.sv
// One-hot select decoder: index of the set bit,
// illegal when two or more bits are set.
module aq_onehot_check
    import aq_mux_pkg::*;
#(
    parameter int NCH = 8
) (
    input  logic [NCH-1:0]         sel_onehot,
    output logic [clog2(NCH)-1:0]  idx,
    output logic                   illegal
);

    localparam int IW = clog2(NCH);

    logic [4:0] nset;

    // Count set bits and remember the last one seen.
    always_comb begin
        idx  = '0;
        nset = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel_onehot[i]) begin
                idx  = IW'(i);
                nset = nset + 5'd1;
            end
        end
        illegal = (nset > 5'd1);
    end

endmodule

// File: rtl/aq_scan_mux.sv
// Channel select mux with direct and round-robin scan
// modes. AQ_SCAN_MUX_PARITY_EN adds out_parity.
module aq_scan_mux
    import aq_mux_pkg::*;
#(
    parameter int             NCH         = 8,
    parameter int             W           = 8,
    parameter int             DWELL       = 4,
    parameter logic [W-1:0]   ERR_PATTERN = W'(ERR_PATTERN_DEF)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH*W-1:0]       ch_data,
    input  logic [NCH-1:0]         ch_valid,
    input  logic                   mode,
    input  logic [NCH-1:0]         sel_onehot,
    output logic [W-1:0]           out_data,
    output logic [clog2(NCH)-1:0]  out_ch,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef AQ_SCAN_MUX_PARITY_EN
    output logic                   out_parity,
`endif
    output logic                   err,
    input  logic                   err_clr
);

    localparam int IW = clog2(NCH);
    localparam int CW = clog2(DWELL);

    state_e         state_q;
    state_e         state_d;
    state_e         mode_st;
    logic [IW-1:0]  ptr_q;
    logic [CW-1:0]  cnt_q;
    logic [IW-1:0]  sel_idx;
    logic           sel_bad;
    logic           stall;
    logic           dwell_end;
    logic           load;
    logic           clr_valid;
    logic           err_set;
    logic [W-1:0]   nxt_data;
    logic [IW-1:0]  nxt_ch;

    aq_onehot_check #(
        .NCH(NCH)
    ) u_chk (
        .sel_onehot(sel_onehot),
        .idx       (sel_idx),
        .illegal   (sel_bad)
    );

    assign stall     = out_valid && !out_ready;
    assign dwell_end = (cnt_q == CW'(DWELL - 1));
    assign mode_st   = (mode_e'(mode) == MODE_SCAN)
                       ? SCAN : DIRECT;

    // Next state, sample selection and handshake control.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        clr_valid = 1'b0;
        err_set   = 1'b0;
        nxt_data  = '0;
        nxt_ch    = '0;
        unique case (state_q)
            IDLE: state_d = mode_st;
            DIRECT: begin
                if (stall) begin
                    state_d = HOLD;
                end else begin
                    state_d = mode_st;
                    if (sel_bad) begin
                        load     = 1'b1;
                        err_set  = 1'b1;
                        nxt_data = ERR_PATTERN;
                    end else if (ch_valid[sel_idx]) begin
                        load     = 1'b1;
                        nxt_ch   = sel_idx;
                        nxt_data = ch_data[sel_idx*W +: W];
                    end
                    clr_valid = !load;
                end
            end
            SCAN: begin
                if (stall) begin
                    state_d = HOLD;
                end else begin
                    state_d = mode_st;
                    if (dwell_end && ch_valid[ptr_q]) begin
                        load     = 1'b1;
                        nxt_ch   = ptr_q;
                        nxt_data = ch_data[ptr_q*W +: W];
                    end
                    clr_valid = !load;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d   = mode_st;
                    clr_valid = 1'b1;
                end
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Scan pointer and dwell counter; idle outside scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (state_q == SCAN) begin
            if (!stall) begin
                if (dwell_end) begin
                    cnt_q <= '0;
                    ptr_q <= (ptr_q == IW'(NCH - 1))
                             ? '0 : ptr_q + 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end else if (state_q != HOLD) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end
    end

    // Output register and valid handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= nxt_data;
            out_ch    <= nxt_ch;
            out_valid <= 1'b1;
        end else if (clr_valid) begin
            out_valid <= 1'b0;
        end
    end

`ifdef AQ_SCAN_MUX_PARITY_EN
    // Parity travels with the data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    out_parity <= 1'b0;
        else if (load) out_parity <= ^nxt_data;
    end
`endif

    // Sticky error flag; a new illegal select beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       err <= 1'b0;
        else if (err_set) err <= 1'b1;
        else if (err_clr) err <= 1'b0;
    end

endmodule

// File: tb/tb_aq_scan_mux.sv
// Scoreboard bench for aq_scan_mux (default params).
// Stimulus pushes expectations; monitor pops on handshake.
module tb_aq_scan_mux;

    localparam int NCH = 8;
    localparam int W   = 8;

    typedef struct {
        logic [2:0] ch;
        logic [7:0] data;
        int         gap;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic [63:0]    ch_data;
    logic [7:0]     ch_valid;
    logic           mode;
    logic [7:0]     sel_onehot;
    logic [7:0]     out_data;
    logic [2:0]     out_ch;
    logic           out_valid;
    logic           out_ready;
    logic           err;
    logic           err_clr;
`ifdef AQ_SCAN_MUX_PARITY_EN
    logic           out_parity;
`endif

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   last  = 0;

    aq_scan_mux #(
        .NCH(NCH), .W(W), .DWELL(4), .ERR_PATTERN(8'h40)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_data   (ch_data),
        .ch_valid  (ch_valid),
        .mode      (mode),
        .sel_onehot(sel_onehot),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef AQ_SCAN_MUX_PARITY_EN
        .out_parity(out_parity),
`endif
        .err       (err),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h",
                     nm, act, req);
        end
    endtask

    task automatic push(input logic [2:0] c,
                        input logic [7:0] d,
                        input int g);
        exp_t e;
        e.ch = c;
        e.data = d;
        e.gap = g;
        q.push_back(e);
    endtask

    // Monitor: pop and compare on each accepted sample.
    initial begin
        exp_t e;
        logic bad;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_sample: ch=%0d data=%h",
                             out_ch, out_data);
                end else begin
                    e = q.pop_front();
                    bad = (out_ch !== e.ch) ||
                          (out_data !== e.data) ||
                          (e.gap != 0 && cyc - last != e.gap);
`ifdef AQ_SCAN_MUX_PARITY_EN
                    if (out_parity !== ^e.data) bad = 1'b1;
`endif
                    if (bad) begin
                        n_err++;
                        $display({"FAIL sample: got ch=%0d ",
                                  "data=%h gap=%0d want ch=%0d ",
                                  "data=%h gap=%0d"},
                                 out_ch, out_data, cyc - last,
                                 e.ch, e.data, e.gap);
                    end
                end
                last = cyc;
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        ch_data    = '0;
        ch_valid   = '0;
        mode       = 1'b0;
        sel_onehot = '0;
        out_ready  = 1'b1;
        err_clr    = 1'b0;
        tick(2);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ch", 32'(out_ch), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Direct, channel 0 via all-zero select.
        ch_data[7:0] = 8'h11;
        ch_valid = 8'h01;
        push(3'd0, 8'h11, 0);
        tick();
        chk("d0_data", 32'(out_data), 32'h11);
        chk("d0_ch", 32'(out_ch), 32'd0);
        chk("d0_valid", 32'(out_valid), 32'd1);
        ch_valid = '0;
        tick();

        // Direct with back-pressure: sample must hold.
        sel_onehot = 8'b0000_1000;
        ch_data[3*8 +: 8] = 8'hA5;
        ch_valid = 8'h08;
        out_ready = 1'b0;
        push(3'd3, 8'hA5, 0);
        tick();
        ch_data[3*8 +: 8] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            chk("hold_data", 32'(out_data), 32'hA5);
            chk("hold_ch", 32'(out_ch), 32'd3);
            tick();
        end
        ch_valid = '0;
        out_ready = 1'b1;
        tick(2);

        // Illegal select and sticky error.
        sel_onehot = 8'b0001_0010;
        push(3'd0, 8'h40, 0);
        tick();
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_data", 32'(out_data), 32'h40);
        chk("ill_ch", 32'(out_ch), 32'd0);
        sel_onehot = 8'b0000_0010;
        err_clr = 1'b1;
        tick();
        chk("clr_err", 32'(err), 32'd0);
        sel_onehot = 8'b0001_0010;
        push(3'd0, 8'h40, 0);
        tick();
        chk("setwins_err", 32'(err), 32'd1);
        sel_onehot = '0;
        err_clr = 1'b0;
        tick();

        // Direct, top channel.
        sel_onehot = 8'h80;
        ch_data[7*8 +: 8] = 8'h7E;
        ch_valid = 8'h80;
        push(3'd7, 8'h7E, 0);
        tick();
        ch_valid = '0;
        sel_onehot = '0;
        tick(2);

        // Scan all channels, wrap back to 0.
        for (int i = 0; i < NCH; i++)
            ch_data[i*8 +: 8] = 8'hC0 + 8'(i);
        mode = 1'b1;
        tick();
        ch_valid = 8'hFF;
        for (int i = 0; i < 9; i++)
            push(3'(i % 8), 8'hC0 + 8'(i % 8),
                 (i == 0) ? 0 : 4);
        tick(36);
        ch_valid = '0;
        tick(3);
        mode = 1'b0;
        tick();

        // Scan with channel 2 skipped.
        mode = 1'b1;
        tick();
        ch_valid = 8'b1111_1011;
        push(3'd0, 8'hC0, 0);
        push(3'd1, 8'hC1, 4);
        push(3'd3, 8'hC3, 8);
        for (int i = 4; i < 8; i++)
            push(3'(i), 8'hC0 + 8'(i), 4);
        tick(32);
        ch_valid = '0;
        tick(3);
        mode = 1'b0;
        tick();

        // Reset while a scan sample is held.
        chk("pre_rst_err", 32'(err), 32'd1);
        mode = 1'b1;
        tick();
        ch_valid = 8'hFF;
        out_ready = 1'b0;
        tick(5);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_ch", 32'(out_ch), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_err", 32'(err), 32'd0);
        chk("async_data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        push(3'd0, 8'hC0, 0);
        push(3'd1, 8'hC1, 4);
        tick();
        tick(8);
        ch_valid = '0;
        tick(3);

        for (int i = 0; i < 20 && q.size() > 0; i++)
            tick();
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d left want 0",
                     q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aq_scan_mux.md
Name: aq_scan_mux

Overview:
- Parametrised successor to the team's one-hot 7-input select mux.
- Selects one of NCH sensor channels, each W bits wide, and registers the result behind a valid/ready output handshake.
- Two operating modes:
  - Direct mode: one-hot select from the control logic.
  - Scan mode: autonomous round-robin with a programmable dwell per channel.
- Illegal select codes are detected, replaced on the output by a fixed error pattern, and recorded in a sticky error flag.

Parameters:
- NCH, 8: number of input channels; legal range 2..16.
- W, 8: data width per channel.
- DWELL, 4: cycles spent on each channel in scan mode; must be >= 1.
- ERR_PATTERN, 'h40: W-bit value driven on out_data for an illegal select.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronous to clk.
- ch_data, input, NCH*W: packed channel data; channel i occupies bits [i*W +: W].
- ch_valid, input, NCH: per-channel data-valid.
- mode, input, 1: 0 = direct, 1 = scan.
- sel_onehot, input, NCH: direct-mode select. All-zero selects channel 0; exactly one bit set selects that channel.
- out_data, output, W: registered selected data.
- out_ch, output, clog2(NCH): index of the channel in out_data; 0 when an error pattern is driven.
- out_valid, output, 1: out_data/out_ch hold a sample.
- out_ready, input, 1: consumer accepts the sample.
- err, output, 1: sticky illegal-select flag.
- err_clr, input, 1: synchronous clear of err.

Behaviour:
- Reset values: out_data=0, out_ch=0, out_valid=0, err=0; scan pointer=0; dwell counter=0; FSM=IDLE.
- FSM states:
  - IDLE: first cycle after reset; goes to DIRECT if mode=0, SCAN if mode=1.
  - DIRECT / SCAN: normal operation in the corresponding mode.
  - HOLD: out_valid=1 && out_ready=0.
- HOLD entry and exit:
  - The FSM enters HOLD whenever a loaded sample is not accepted.
  - In HOLD, out_data, out_ch and out_valid stay stable, and the dwell counter and scan pointer freeze.
  - The FSM leaves HOLD to the mode state on the cycle out_ready=1.
- Load condition: the output register loads when (!out_valid || out_ready) and a sample is available. If no sample is available, out_valid clears on handshake.
- Direct mode:
  - A sample is available when the selected channel's ch_valid=1, or when the select is illegal.
  - Latency is 1 cycle from sel_onehot/ch_data to out_data.
  - Illegal select means two or more bits set: out_data=ERR_PATTERN, out_ch=0, out_valid=1, and err sets in the same cycle.
- Scan mode:
  - The dwell counter counts 0..DWELL-1 on the current pointer channel.
  - At DWELL-1, the channel is sampled if its ch_valid=1. The pointer then advances, wrapping NCH-1 -> 0, and the counter returns to 0.
  - A channel with ch_valid=0 is skipped and produces no sample.
  - sel_onehot is ignored in scan mode.
- Mode change:
  - Takes effect on the next cycle, but not while in HOLD; it is deferred until the held sample is accepted.
  - Entering SCAN resets the pointer and dwell counter to 0.
- err behaviour: err_clr and a new illegal select in the same cycle leave err=1 (set wins).
- Reset mid-operation: all state returns to reset values immediately, and any held sample is discarded.

Optional Feature:
- Macro: AQ_SCAN_MUX_PARITY_EN.
- When defined, add output out_parity (1 bit), the even parity of out_data. It is registered with out_data and held with it in HOLD, and resets to 0. For ERR_PATTERN it is the parity of ERR_PATTERN.
- When undefined, the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package aq_mux_pkg contains:
  - mode enum (MODE_DIRECT, MODE_SCAN);
  - FSM state enum (IDLE, DIRECT, SCAN, HOLD);
  - default ERR_PATTERN constant;
  - clog2 helper constant function.
- Sub-module aq_onehot_check (combinational, NCH-parameterised) takes sel_onehot and outputs idx and illegal. All-zero gives idx=0, illegal=0.

Test Plan:
- Reset, then mode=0, sel_onehot=0, ch_valid[0]=1, ch0=8'h11, out_ready=1 -> next cycle out_data=8'h11, out_ch=0, out_valid=1.
- Direct, sel_onehot=8'b0000_1000, ch3=8'hA5, out_ready=0 for 3 cycles while ch3 changes to 8'h00 -> out_data holds 8'hA5, out_ch=3 until out_ready=1.
- Direct, sel_onehot=8'b0001_0010 -> out_data=8'h40, out_ch=0, err=1. Then err_clr=1 with a legal select -> err=0. Then err_clr=1 with an illegal select in the same cycle -> err stays 1.
- Scan, DWELL=4, ch_valid=8'hFF, out_ready=1 -> samples on channels 0,1,...,7,0 at 4-cycle spacing; the pointer wraps after 7.
- Scan, ch_valid=8'b1111_1011 -> channel 2 never appears in out_ch; the remaining channels appear in order.
- Scan mid-dwell, assert rst_n=0 for 1 cycle -> out_valid=0 and err=0 asynchronously; after release the scan restarts at channel 0.
